// File: rtl/cs_window_filter_pkg.sv
// Shared definitions for the window filter: mode encodings and the sum-width helper.
package cs_pkg;

    typedef enum logic {
        CS_MODE_FLOOR = 1'b0,
        CS_MODE_CEIL  = 1'b1
    } cs_mode_e;

    // Width that holds the sum of depth samples of data_w bits without overflow.
    function automatic int cs_sum_w(input int data_w, input int depth);
        return data_w + $clog2(depth);
    endfunction

endpackage

// File: rtl/cs_window_stats.sv
// Combinational window statistics: full-precision sum, floor average, and the
// nearest sample at or below (floor mode) / at or above (ceiling mode) that average.
module cs_window_stats
    import cs_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 9,
    parameter int SUM_W  = cs_sum_w(DATA_W, DEPTH)
) (
    input  logic [DATA_W-1:0] i_win [DEPTH],
    input  logic              i_mode,
    output logic [SUM_W-1:0]  o_sum,
    output logic [DATA_W-1:0] o_appr
);

    logic [SUM_W-1:0]  w_sum;
    logic [SUM_W-1:0]  w_avg;
    logic [DATA_W-1:0] w_appr;
    logic              w_found;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_sum = w_sum + SUM_W'(i_win[i]);
        end
    end

    assign w_avg = w_sum / SUM_W'(DEPTH);

    // The average always lies between the window min and max, so a match always exists.
    always_comb begin
        w_appr  = '0;
        w_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_mode == CS_MODE_CEIL) begin
                if ((SUM_W'(i_win[i]) >= w_avg) && (!w_found || (i_win[i] < w_appr))) begin
                    w_appr  = i_win[i];
                    w_found = 1'b1;
                end
            end else begin
                if ((SUM_W'(i_win[i]) <= w_avg) && (!w_found || (i_win[i] > w_appr))) begin
                    w_appr  = i_win[i];
                    w_found = 1'b1;
                end
            end
        end
    end

    assign o_sum  = w_sum;
    assign o_appr = w_appr;

endmodule

// File: rtl/cs_window_filter.sv
// Sliding-window filter y = (sum + DEPTH*appr) >> SHIFT; one-cycle latency, input stalls while y is held.
// CS_WINDOW_SAT_EN: saturate an oversized result to all-ones instead of truncating it.
module cs_window_filter
    import cs_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 9,
    parameter int SHIFT  = 3,
    parameter int OUT_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  y
);

    localparam int SW = cs_sum_w(DATA_W, DEPTH);
    localparam int RW = SW + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_win [DEPTH];
    logic [PW-1:0]     r_wp;
    logic [FW-1:0]     r_fill;
    logic              r_pend;
    logic              r_out_valid;
    logic [OUT_W-1:0]  r_y;

    logic              w_accept;
    logic              w_load;
    logic              w_pend_set;
    logic [FW-1:0]     w_fill_nxt;
    logic [SW-1:0]     w_sum;
    logic [DATA_W-1:0] w_appr;
    logic [RW-1:0]     w_res;
    logic [OUT_W-1:0]  w_y_fit;

    assign in_ready   = !(r_out_valid && !out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_fill_nxt = (r_fill == FW'(DEPTH)) ? r_fill : r_fill + 1'b1;
    assign w_pend_set = w_accept && (w_fill_nxt == FW'(DEPTH));
    assign w_load     = r_pend && (!r_out_valid || out_ready);

    cs_window_stats #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .SUM_W  (SW)
    ) u_stats (
        .i_win  (r_win),
        .i_mode (mode),
        .o_sum  (w_sum),
        .o_appr (w_appr)
    );

    // sum + DEPTH*appr is at most twice the largest possible sum, so RW bits suffice.
    assign w_res = (RW'(w_sum) + RW'(DEPTH) * RW'(w_appr)) >> SHIFT;

`ifdef CS_WINDOW_SAT_EN
    localparam int EW = (RW > OUT_W) ? RW : OUT_W;
    logic [EW-1:0] w_res_ext;
    assign w_res_ext = EW'(w_res);
    assign w_y_fit   = (w_res_ext > EW'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : w_res_ext[OUT_W-1:0];
`else
    assign w_y_fit = OUT_W'(w_res);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_win[i] <= '0;
            r_wp        <= '0;
            r_fill      <= '0;
            r_pend      <= 1'b0;
            r_out_valid <= 1'b0;
            r_y         <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) r_win[i] <= '0;
            r_wp        <= '0;
            r_fill      <= '0;
            r_pend      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_win[r_wp] <= x;
                r_wp        <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
                r_fill      <= w_fill_nxt;
            end
            if (w_pend_set) begin
                r_pend <= 1'b1;
            end else if (w_load) begin
                r_pend <= 1'b0;
            end
            // The result reflects the window as it stood before this edge's accept.
            if (w_load) begin
                r_y         <= w_y_fit;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;

endmodule

// File: tb/tb_cs_window_filter.sv
// Self-checking bench: table vectors, directed corner sequences and a randomized
// run against a queue-based reference model; a second instance uses OUT_W=9.
module tb_cs_window_filter;

    localparam int DEPTH = 9;
    localparam int SHIFT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       mode;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] x;
    logic       in_ready, out_valid;
    logic       in_ready9, out_valid9;
    logic [9:0] y;
    logic [8:0] y9;

    cs_window_filter #(.DATA_W(8), .DEPTH(DEPTH), .SHIFT(SHIFT), .OUT_W(10)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    cs_window_filter #(.DATA_W(8), .DEPTH(DEPTH), .SHIFT(SHIFT), .OUT_W(9)) u_dut9 (
        .clk(clk), .reset(reset), .flush(flush), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready9), .x(x),
        .out_valid(out_valid9), .out_ready(out_ready), .y(y9)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int r_floor;
        int r_ceil;
    } exp_t;

    int   win_q[$];
    int   acc_cnt;
    exp_t exp_q[$];

    typedef struct {
        int s [9];
        bit m;
        int ey;
        int ey9;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference result straight from the definition: sum, floor average, nearest sample.
    function automatic int ref_res(input bit m);
        int sum, avg, appr;
        sum = 0;
        foreach (win_q[i]) sum += win_q[i];
        avg  = sum / DEPTH;
        appr = m ? 1 << 30 : -1;
        foreach (win_q[i]) begin
            if (!m && win_q[i] <= avg && win_q[i] > appr) appr = win_q[i];
            if (m && win_q[i] >= avg && win_q[i] < appr) appr = win_q[i];
        end
        return (sum + DEPTH * appr) >> SHIFT;
    endfunction

    function automatic int fit(input int r, input int w);
        int lim;
        lim = (1 << w) - 1;
`ifdef CS_WINDOW_SAT_EN
        return (r > lim) ? lim : r;
`else
        return r & lim;
`endif
    endfunction

    function automatic void model_clear();
        win_q.delete();
        exp_q.delete();
        acc_cnt = 0;
    endfunction

    // One clock with full scoreboard checking; caller drives inputs after it returns.
    task automatic tick();
        logic        ov_pre, ordy, fl, m, exp_rdy, acc, exp_load, exp_ov;
        logic [31:0] y_pre, y9_pre;
        int          xs, r;
        exp_t        e;
        #1;
        ov_pre = out_valid;
        ordy   = out_ready;
        fl     = flush;
        m      = mode;
        xs     = int'(x);
        y_pre  = 32'(y);
        y9_pre = 32'(y9);
        exp_rdy = !(ov_pre && !ordy);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("in_ready9", 32'(in_ready9), 32'(exp_rdy));
        acc      = in_valid && exp_rdy && !fl;
        exp_load = (exp_q.size() > 0) && exp_rdy && !fl;
        exp_ov   = !fl && (exp_load || (ov_pre && !ordy));
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("out_valid9", 32'(out_valid9), 32'(exp_ov));
        if (exp_load) begin
            e = exp_q.pop_front();
            r = m ? e.r_ceil : e.r_floor;
            chk("y", 32'(y), 32'(fit(r, 10)));
            chk("y9", 32'(y9), 32'(fit(r, 9)));
        end else begin
            chk("y_hold", 32'(y), y_pre);
            chk("y9_hold", 32'(y9), y9_pre);
        end
        if (fl) begin
            model_clear();
        end else if (acc) begin
            win_q.push_back(xs);
            if (win_q.size() > DEPTH) void'(win_q.pop_front());
            acc_cnt++;
            if (acc_cnt >= DEPTH) exp_q.push_back('{ref_res(1'b0), ref_res(1'b1)});
        end
    endtask

    task automatic feed(input int v);
        in_valid = 1'b1;
        x        = 8'(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        idle();
        flush = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_y", 32'(y), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
    endtask

    initial begin
        tbl[0] = '{'{1, 2, 3, 4, 5, 6, 7, 8, 9}, 1'b0, 11, 11};
        tbl[1] = '{'{0, 0, 0, 0, 0, 0, 0, 0, 100}, 1'b0, 12, 12};
        tbl[2] = '{'{0, 0, 0, 0, 0, 0, 0, 0, 100}, 1'b1, 125, 125};
`ifdef CS_WINDOW_SAT_EN
        tbl[3] = '{'{255, 255, 255, 255, 255, 255, 255, 255, 255}, 1'b0, 573, 511};
`else
        tbl[3] = '{'{255, 255, 255, 255, 255, 255, 255, 255, 255}, 1'b0, 573, 61};
`endif

        reset = 1'b1; flush = 1'b0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0;
        model_clear();
        #3;
        chk("por_out_valid", 32'(out_valid), 32'd0);
        chk("por_y", 32'(y), 32'd0);
        chk("por_y9", 32'(y9), 32'd0);
        chk("por_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table vectors: each row from an empty window
        for (int r = 0; r < 4; r++) begin
            do_flush();
            mode = tbl[r].m;
            for (int k = 0; k < DEPTH; k++) begin
                feed(tbl[r].s[k]);
                chk($sformatf("row%0d_no_early_valid_%0d", r, k), 32'(out_valid), 32'd0);
            end
            idle();
            chk($sformatf("row%0d_valid", r), 32'(out_valid), 32'd1);
            chk($sformatf("row%0d_y", r), 32'(y), 32'(tbl[r].ey));
            chk($sformatf("row%0d_y9", r), 32'(y9), 32'(tbl[r].ey9));
        end

        // Sliding by one sample, then an output stall with a sample waiting
        do_flush();
        mode = 1'b0;
        for (int k = 1; k <= 9; k++) feed(k);
        idle();
        chk("slide_first_y", 32'(y), 32'd11);
        feed(0);
        idle();
        chk("slide_y", 32'(y), 32'd10);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        x         = 8'd50;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_y", 32'(y), 32'd10);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        idle();
        chk("release_valid", 32'(out_valid), 32'd1);
        chk("release_y", 32'(y), 32'd21);

        // Clear after five samples, by flush and then by reset
        for (int v = 0; v < 2; v++) begin
            do_flush();
            for (int k = 0; k < 5; k++) feed(200);
            if (v == 0) do_flush();
            else do_reset();
            for (int k = 1; k <= 8; k++) begin
                feed(10 * k);
                chk($sformatf("clear%0d_no_result_%0d", v, k), 32'(out_valid), 32'd0);
            end
            feed(90);
            idle();
            chk($sformatf("clear%0d_valid", v), 32'(out_valid), 32'd1);
            chk($sformatf("clear%0d_y", v), 32'(y), 32'd112);
        end

        // Randomized traffic with back-pressure, mode changes and occasional flush
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            x         = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 9) < 7);
            mode      = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 79) == 0);
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle();
        idle();
        chk("drain_pending", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
